// File: rtl/instr_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage and the length decoder.
package instr_fetch_pkg;

  typedef enum logic [1:0] {StReq, StCap, StHold} fetch_state_e;

  typedef enum logic [1:0] {FmtIll, FmtI, FmtII, FmtJ} fmt_e;

  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_INC = 2'b11;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_CG = 4'd3;

  localparam logic [1:0] LEN_1 = 2'd1;

  function automatic fmt_e op_format(logic [15:0] op);
    if (op[15:14] != 2'b00) return FmtI;
    if (op[15:13] == 3'b001) return FmtJ;
    if (op[15:12] == 4'b0001) return FmtII;
    return FmtIll;
  endfunction

  // R3 is a pure constant generator; @R0+ is an immediate, so it needs a word.
  function automatic logic needs_ext(logic [1:0] as_mode, logic [3:0] rsel);
    return ((as_mode == AS_IDX) && (rsel != REG_CG)) ||
           ((as_mode == AS_INC) && (rsel == REG_PC));
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM bus and decoder-side instruction bundle of the fetch stage.
interface instr_fetch_if;
  logic [15:0] rom_addr;
  logic        rom_rd;
  logic [15:0] rom_data;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word;
  logic [15:0] ir_ext1;
  logic [15:0] ir_ext2;
  logic [1:0]  ir_len;
  logic [15:0] ir_pc;
  logic [15:0] ir_next_pc;
  logic        ir_illegal;

  modport master (
    output rom_addr, rom_rd, ir_valid, ir_word, ir_ext1, ir_ext2, ir_len, ir_pc, ir_next_pc,
           ir_illegal,
    input  rom_data, pc_load, pc_load_val, ir_ready
  );

  modport slave (
    input  rom_addr, rom_rd, ir_valid, ir_word, ir_ext1, ir_ext2, ir_len, ir_pc, ir_next_pc,
           ir_illegal,
    output rom_data, pc_load, pc_load_val, ir_ready
  );
endinterface

// File: rtl/instr_len.sv
// Combinational instruction length decoder: opcode word in, total word count out.
module instr_len
  import instr_fetch_pkg::*;
(
  input  logic [15:0] opcode,
  output logic [1:0]  len,
  output logic        has_src_ext,
  output logic        has_dst_ext,
  output logic        illegal
);

  logic unused_bw;
  assign unused_bw = opcode[6];

  always_comb begin
    has_src_ext = 1'b0;
    has_dst_ext = 1'b0;
    illegal     = 1'b0;
    unique case (op_format(opcode))
      FmtI: begin
        has_src_ext = needs_ext(opcode[5:4], opcode[11:8]);
        has_dst_ext = opcode[7];
      end
      FmtII:   has_src_ext = needs_ext(opcode[5:4], opcode[3:0]);
      FmtJ:    ;
      default: illegal = 1'b1;
    endcase
    len = LEN_1 + {1'b0, has_src_ext} + {1'b0, has_dst_ext};
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads 1..3 words per instruction from ROM and hands the bundle to the decoder.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'hC000
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [1:0]   widx_q, widx_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  ir_word_q, ir_word_d;
  logic [15:0]  ir_ext1_q, ir_ext1_d;
  logic [15:0]  ir_ext2_q, ir_ext2_d;
  logic [1:0]   ir_len_q, ir_len_d;
  logic [15:0]  ir_pc_q, ir_pc_d;
  logic [15:0]  ir_next_pc_q, ir_next_pc_d;
  logic         ir_illegal_q, ir_illegal_d;

  logic [1:0]   dec_len;
  logic [1:0]   cur_len;
  logic         dec_illegal;
  logic         unused_src_ext, unused_dst_ext, unused_load_lsb;

  assign unused_load_lsb = bus.pc_load_val[0];

  instr_len u_len (
    .opcode      (bus.rom_data),
    .len         (dec_len),
    .has_src_ext (unused_src_ext),
    .has_dst_ext (unused_dst_ext),
    .illegal     (dec_illegal)
  );

  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    fetch_pc_d   = fetch_pc_q;
    ir_word_d    = ir_word_q;
    ir_ext1_d    = ir_ext1_q;
    ir_ext2_d    = ir_ext2_q;
    ir_len_d     = ir_len_q;
    ir_pc_d      = ir_pc_q;
    ir_next_pc_d = ir_next_pc_q;
    ir_illegal_d = ir_illegal_q;
    cur_len      = (widx_q == 2'd0) ? dec_len : ir_len_q;

    case (state_q)
      StReq: state_d = StCap;
      StCap: begin
        case (widx_q)
          2'd0: begin
            ir_word_d    = bus.rom_data;
            ir_len_d     = dec_len;
            ir_illegal_d = dec_illegal;
            ir_pc_d      = fetch_pc_q;
            ir_next_pc_d = fetch_pc_q + {13'd0, dec_len, 1'b0};
            ir_ext1_d    = 16'h0000;
            ir_ext2_d    = 16'h0000;
          end
          2'd1:    ir_ext1_d = bus.rom_data;
          default: ir_ext2_d = bus.rom_data;
        endcase
        if ((widx_q + 2'd1) < cur_len) begin
          widx_d  = widx_q + 2'd1;
          state_d = StReq;
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.ir_ready) begin
          fetch_pc_d = ir_next_pc_q;
          widx_d     = 2'd0;
          state_d    = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Redirect wins; a word already in flight is dropped because we never enter StCap for it.
    if (bus.pc_load) begin
      state_d    = StReq;
      widx_d     = 2'd0;
      fetch_pc_d = {bus.pc_load_val[15:1], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StReq;
      widx_q       <= 2'd0;
      fetch_pc_q   <= RESET_PC;
      ir_word_q    <= 16'h0000;
      ir_ext1_q    <= 16'h0000;
      ir_ext2_q    <= 16'h0000;
      ir_len_q     <= LEN_1;
      ir_pc_q      <= 16'h0000;
      ir_next_pc_q <= 16'h0000;
      ir_illegal_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      fetch_pc_q   <= fetch_pc_d;
      ir_word_q    <= ir_word_d;
      ir_ext1_q    <= ir_ext1_d;
      ir_ext2_q    <= ir_ext2_d;
      ir_len_q     <= ir_len_d;
      ir_pc_q      <= ir_pc_d;
      ir_next_pc_q <= ir_next_pc_d;
      ir_illegal_q <= ir_illegal_d;
    end
  end

  assign bus.rom_rd     = (state_q == StReq) && !rst;
  assign bus.rom_addr   = fetch_pc_q + {13'd0, widx_q, 1'b0};
  assign bus.ir_valid   = (state_q == StHold);
  assign bus.ir_word    = ir_word_q;
  assign bus.ir_ext1    = ir_ext1_q;
  assign bus.ir_ext2    = ir_ext2_q;
  assign bus.ir_len     = ir_len_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.ir_next_pc = ir_next_pc_q;
  assign bus.ir_illegal = ir_illegal_q;

endmodule
